si5340_i2c_bus_arbiter: RTL and testbench

Shares one open-drain I2C pad set (SCL/SDA to the Si5340) between NUM_REQ I2C masters, e.g. si5340_config_loader plus a status poller.
- Round-robin req/gnt handshake.
- Registered pad muxing.
- Enforced bus-free guard time between owners.
- Sits between the masters' pad-level outputs and the top-level IOBUF pair.

---
 rtl/si5340_i2c_bus_arbiter_pkg.sv | 49 ++++
 rtl/si5340_i2c_bus_arbiter_rr_picker.sv | 36 +++
 rtl/si5340_i2c_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_si5340_i2c_bus_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/si5340_i2c_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : si5340_arb_pkg
// Description : Shared types, pad constants and the round-robin selection
//               function for the Si5340 I2C bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package si5340_arb_pkg;

    // Widest supported requester set; index registers are sized for it.
    localparam int c_MAX_REQ = 8;
    localparam int c_IDX_W   = 3;

    // Released pad values: output enable off, output data low.
    localparam logic PAD_OEN_OFF = 1'b1;
    localparam logic PAD_O_IDLE  = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } arb_state_t;

    // First asserted request strictly after ptr, wrapping modulo num.
    // Returns 0 when nothing is requested; callers qualify with |req.
    function automatic logic [c_IDX_W-1:0] rr_pick(
        input logic [c_MAX_REQ-1:0] req,
        input logic [c_IDX_W-1:0]   ptr,
        input int                   num
    );
        logic [c_IDX_W-1:0]   pick;
        logic                 found;
        logic [c_MAX_REQ-1:0] shifted;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= c_MAX_REQ; off++) begin
            idx     = (int'(ptr) + off) % num;
            shifted = req >> idx;
            if ((off <= num) && !found && shifted[0]) begin
                pick  = c_IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/si5340_i2c_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : si5340_rr_picker
// Description : Combinational round-robin selector. Given the request vector
//               and the last winner, returns the next winner as an index and
//               as a one-hot vector, plus a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module si5340_rr_picker
    import si5340_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [c_IDX_W-1:0] i_ptr,
    output logic               o_valid,
    output logic [c_IDX_W-1:0] o_idx,
    output logic [NUM_REQ-1:0] o_onehot
);

    logic [c_MAX_REQ-1:0] w_req_ext;

    // Widen the request vector, pick the next index and expand it to one-hot.
    always_comb begin
        w_req_ext                = '0;
        w_req_ext[NUM_REQ-1:0]   = i_req;
        o_valid                  = |i_req;
        o_idx                    = rr_pick(w_req_ext, i_ptr, NUM_REQ);
        o_onehot                 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_onehot[i] = o_valid && (o_idx == c_IDX_W'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/si5340_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : si5340_i2c_bus_arbiter
// Description : Shares one open-drain SCL/SDA pad set between NUM_REQ I2C
//               masters. Round-robin req/gnt, registered pad mux and a
//               released-bus guard interval between consecutive owners.
//               Optional grant timeout: define SI5340_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module si5340_i2c_bus_arbiter
    import si5340_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int GUARD_CYCLES   = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    input  logic [NUM_REQ-1:0] m_scl_o_i,
    input  logic [NUM_REQ-1:0] m_scl_oen_i,
    input  logic [NUM_REQ-1:0] m_sda_o_i,
    input  logic [NUM_REQ-1:0] m_sda_oen_i,
    input  logic               scl_pad_i,
    input  logic               sda_pad_i,
    output logic               scl_pad_o,
    output logic               scl_padoen_o,
    output logic               sda_pad_o,
    output logic               sda_padoen_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int                   c_GUARD_W    = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_GUARD_W-1:0] c_GUARD_LOAD = c_GUARD_W'(GUARD_CYCLES - 1);

    arb_state_t           r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [c_IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [c_GUARD_W-1:0] r_guard_cnt, w_guard_cnt_nxt;
    logic                 r_scl_o, w_scl_o_nxt;
    logic                 r_scl_oen, w_scl_oen_nxt;
    logic                 r_sda_o, w_sda_o_nxt;
    logic                 r_sda_oen, w_sda_oen_nxt;
    logic                 r_busy, w_busy_nxt;

    logic                 w_owner_req;
    logic                 w_owner_scl_o, w_owner_scl_oen;
    logic                 w_owner_sda_o, w_owner_sda_oen;
    logic [NUM_REQ-1:0]   w_req_eligible;
    logic                 w_revoke;
    logic                 w_pick_valid;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic [NUM_REQ-1:0]   w_pick_onehot;

    // The bus samples are fanned out to the masters outside this block.
    logic                 w_unused_pad_sample;
    assign w_unused_pad_sample = scl_pad_i ^ sda_pad_i;

    // Owner selection through the one-hot grant: non-owners never reach the pads.
    assign w_owner_req     = |(req_i & r_gnt);
    assign w_owner_scl_o   = |(m_scl_o_i & r_gnt);
    assign w_owner_scl_oen = ~|(~m_scl_oen_i & r_gnt);
    assign w_owner_sda_o   = |(m_sda_o_i & r_gnt);
    assign w_owner_sda_oen = ~|(~m_sda_oen_i & r_gnt);

`ifdef SI5340_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0]  r_to_cnt;
    logic [NUM_REQ-1:0] r_blocked;
    logic               r_timeout;

    // Grant is revoked on the cycle the owner has held it TIMEOUT_CYCLES cycles.
    assign w_revoke       = (r_state == GRANT) && w_owner_req &&
                            (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
    // A revoked master must show req low once before it may win again.
    assign w_req_eligible = req_i & ~r_blocked;
    assign timeout_o      = r_timeout;

    // Grant-hold counter, per-master block mask and sticky timeout flag.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_to_cnt  <= '0;
            r_blocked <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != GRANT) begin
                r_to_cnt <= '0;
            end else if (!w_revoke) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_blocked <= (r_blocked & req_i) | (w_revoke ? r_gnt : '0);
            r_timeout <= r_timeout | w_revoke;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_revoke         = 1'b0;
    assign w_req_eligible   = req_i;
    assign timeout_o        = 1'b0;
`endif

    si5340_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .i_req    (w_req_eligible),
        .i_ptr    (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx),
        .o_onehot (w_pick_onehot)
    );

    // Next state, grant, guard count and pad values; pads default to released.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_guard_cnt_nxt = r_guard_cnt;
        w_scl_o_nxt     = PAD_O_IDLE;
        w_scl_oen_nxt   = PAD_OEN_OFF;
        w_sda_o_nxt     = PAD_O_IDLE;
        w_sda_oen_nxt   = PAD_OEN_OFF;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt  = GRANT;
                    w_gnt_nxt    = w_pick_onehot;
                    w_rr_ptr_nxt = w_pick_idx;
                end
            end
            GRANT: begin
                if (!w_owner_req || w_revoke) begin
                    w_state_nxt     = GUARD;
                    w_gnt_nxt       = '0;
                    w_guard_cnt_nxt = c_GUARD_LOAD;
                end else begin
                    w_scl_o_nxt   = w_owner_scl_o;
                    w_scl_oen_nxt = w_owner_scl_oen;
                    w_sda_o_nxt   = w_owner_sda_o;
                    w_sda_oen_nxt = w_owner_sda_oen;
                end
            end
            GUARD: begin
                if (r_guard_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_guard_cnt_nxt = r_guard_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_rr_ptr    <= c_IDX_W'(NUM_REQ - 1);
            r_guard_cnt <= '0;
            r_scl_o     <= PAD_O_IDLE;
            r_scl_oen   <= PAD_OEN_OFF;
            r_sda_o     <= PAD_O_IDLE;
            r_sda_oen   <= PAD_OEN_OFF;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_guard_cnt <= w_guard_cnt_nxt;
            r_scl_o     <= w_scl_o_nxt;
            r_scl_oen   <= w_scl_oen_nxt;
            r_sda_o     <= w_sda_o_nxt;
            r_sda_oen   <= w_sda_oen_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign gnt_o        = r_gnt;
    assign scl_pad_o    = r_scl_o;
    assign scl_padoen_o = r_scl_oen;
    assign sda_pad_o    = r_sda_o;
    assign sda_padoen_o = r_sda_oen;
    assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_si5340_i2c_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_si5340_i2c_bus_arbiter
// Description : Self-checking bench for si5340_i2c_bus_arbiter: directed
//               scenarios plus randomized traffic against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_si5340_i2c_bus_arbiter;

    localparam int N  = 3;
    localparam int G  = 6;
    localparam int TO = 50;

    logic         clk_i       = 1'b0;
    logic         arstn_i     = 1'b0;
    logic [N-1:0] req_i       = '0;
    logic [N-1:0] m_scl_o_i   = '0;
    logic [N-1:0] m_scl_oen_i = '1;
    logic [N-1:0] m_sda_o_i   = '0;
    logic [N-1:0] m_sda_oen_i = '1;
    logic         scl_pad_i   = 1'b1;
    logic         sda_pad_i   = 1'b1;
    logic [N-1:0] gnt_o;
    logic         scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o, busy_o, timeout_o;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Reference model: current owner (-1 none), last winner, and the edge
    // after which the arbiter is idle again following a release.
    int           m_owner, m_last, m_idle_at;
    logic [N-1:0] e_gnt;
    logic         e_scl_o, e_scl_oen, e_sda_o, e_sda_oen, e_busy;

    always #5 clk_i = ~clk_i;

    si5340_i2c_bus_arbiter #(
        .NUM_REQ        (N),
        .GUARD_CYCLES   (G),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .arstn_i      (arstn_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .m_scl_o_i    (m_scl_o_i),
        .m_scl_oen_i  (m_scl_oen_i),
        .m_sda_o_i    (m_sda_o_i),
        .m_sda_oen_i  (m_sda_oen_i),
        .scl_pad_i    (scl_pad_i),
        .sda_pad_i    (sda_pad_i),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] s;
        s = v >> i;
        return s[0];
    endfunction

    function automatic int rr_next(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (bit_at(r, (last + k) % N)) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_last    = N - 1;
        m_idle_at = -1;
        e_gnt     = '0;
        e_scl_o   = 1'b0;
        e_scl_oen = 1'b1;
        e_sda_o   = 1'b0;
        e_sda_oen = 1'b1;
        e_busy    = 1'b0;
    endtask

    // Expected outputs after the coming clock edge, from the inputs it samples.
    task automatic model_edge();
        int p;
        e_scl_o   = 1'b0;
        e_scl_oen = 1'b1;
        e_sda_o   = 1'b0;
        e_sda_oen = 1'b1;
        if (m_owner >= 0) begin
            if (!bit_at(req_i, m_owner)) begin
                m_owner   = -1;
                m_idle_at = cyc + G;
            end else begin
                e_scl_o   = bit_at(m_scl_o_i, m_owner);
                e_scl_oen = bit_at(m_scl_oen_i, m_owner);
                e_sda_o   = bit_at(m_sda_o_i, m_owner);
                e_sda_oen = bit_at(m_sda_oen_i, m_owner);
            end
        end else if (cyc > m_idle_at) begin
            p = rr_next(req_i, m_last);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
            end
        end
        e_gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_busy = (m_owner >= 0) || (cyc < m_idle_at);
    endtask

    // Inputs are set 1 time unit after an edge; outputs are read 1 unit after.
    task automatic step();
        model_edge();
        @(posedge clk_i);
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        req_i   = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (gnt_o !== '0 || busy_o !== 1'b0 || scl_padoen_o !== 1'b1 || sda_padoen_o !== 1'b1 ||
            scl_pad_o !== 1'b0 || sda_pad_o !== 1'b0 || timeout_o !== 1'b0)
            $display("FAIL reset: gnt=%b busy=%b scl_oen=%b sda_oen=%b scl_o=%b sda_o=%b to=%b, expected 000 0 1 1 0 0 0",
                     gnt_o, busy_o, scl_padoen_o, sda_padoen_o, scl_pad_o, sda_pad_o, timeout_o);
        else passed++;
        arstn_i = 1'b1;
        repeat (3) step();
        checks++;
        if (gnt_o !== '0 || busy_o !== 1'b0)
            $display("FAIL idle_no_req: gnt=%b busy=%b, expected 000 0", gnt_o, busy_o);
        else passed++;
    endtask

    task automatic test_single_request();
        m_scl_o_i   = '0;
        m_sda_o_i   = '0;
        m_scl_oen_i = 3'b110;
        m_sda_oen_i = 3'b110;
        req_i       = 3'b001;
        step();
        checks++;
        if (gnt_o !== 3'b001 || busy_o !== 1'b1 || scl_padoen_o !== 1'b1)
            $display("FAIL grant_latency: gnt=%b busy=%b scl_oen=%b, expected 001 1 1", gnt_o, busy_o, scl_padoen_o);
        else passed++;
        step();
        checks++;
        if (scl_padoen_o !== 1'b0 || sda_padoen_o !== 1'b0)
            $display("FAIL owner_drive: scl_oen=%b sda_oen=%b, expected 0 0", scl_padoen_o, sda_padoen_o);
        else passed++;
        m_sda_o_i   = 3'b001;
        m_sda_oen_i = 3'b001;
        m_scl_oen_i = 3'b000;
        step();
        checks++;
        if (sda_pad_o !== 1'b1 || sda_padoen_o !== 1'b1 || scl_padoen_o !== 1'b0)
            $display("FAIL owner_mux: sda_o=%b sda_oen=%b scl_oen=%b, expected 1 1 0", sda_pad_o, sda_padoen_o, scl_padoen_o);
        else passed++;
    endtask

    task automatic test_guard();
        req_i = 3'b011;
        repeat (2) step();
        checks++;
        if (gnt_o !== 3'b001)
            $display("FAIL no_preempt: gnt=%b, expected 001", gnt_o);
        else passed++;
        m_scl_oen_i = 3'b000;
        m_sda_oen_i = 3'b000;
        req_i       = 3'b010;
        step();
        checks++;
        if (gnt_o !== '0 || scl_padoen_o !== 1'b1 || sda_padoen_o !== 1'b1 || busy_o !== 1'b1)
            $display("FAIL release: gnt=%b scl_oen=%b sda_oen=%b busy=%b, expected 000 1 1 1",
                     gnt_o, scl_padoen_o, sda_padoen_o, busy_o);
        else passed++;
        for (int i = 0; i < G; i++) begin
            step();
            checks++;
            if (gnt_o !== '0 || scl_padoen_o !== 1'b1 || sda_padoen_o !== 1'b1 || busy_o !== (i < G - 1))
                $display("FAIL guard_cycle%0d: gnt=%b scl_oen=%b sda_oen=%b busy=%b, expected 000 1 1 %b",
                         i, gnt_o, scl_padoen_o, sda_padoen_o, busy_o, (i < G - 1));
            else passed++;
        end
        step();
        checks++;
        if (gnt_o !== 3'b010)
            $display("FAIL grant_after_guard: gnt=%b, expected 010", gnt_o);
        else passed++;
        req_i = '0;
        step();
    endtask

    task automatic test_reset_mid_grant();
        int waited;
        m_sda_o_i   = '0;
        m_sda_oen_i = 3'b101;
        m_scl_oen_i = 3'b111;
        req_i       = 3'b010;
        waited      = 0;
        while (gnt_o === '0 && waited < G + 5) begin
            step();
            waited++;
        end
        checks++;
        if (gnt_o !== 3'b010)
            $display("FAIL regrant_m1: gnt=%b, expected 010", gnt_o);
        else passed++;
        step();
        checks++;
        if (sda_padoen_o !== 1'b0)
            $display("FAIL m1_drive: sda_oen=%b, expected 0", sda_padoen_o);
        else passed++;
        #2;
        arstn_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (sda_padoen_o !== 1'b1 || gnt_o !== '0 || busy_o !== 1'b0)
            $display("FAIL async_reset: sda_oen=%b gnt=%b busy=%b, expected 1 000 0", sda_padoen_o, gnt_o, busy_o);
        else passed++;
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        req_i   = '1;
        step();
        checks++;
        if (gnt_o !== 3'b001)
            $display("FAIL rr_after_reset: gnt=%b, expected 001", gnt_o);
        else passed++;
    endtask

    task automatic test_round_robin();
        int   owner, nxt, waited, hold;
        logic x_scl_oen, x_sda_oen, x_sda_o;
        owner = 0;
        for (int r = 0; r < 6; r++) begin
            hold = 4 + int'($urandom_range(4, 0));
            repeat (hold) begin
                m_scl_o_i   = N'($urandom);
                m_scl_oen_i = N'($urandom);
                m_sda_o_i   = N'($urandom);
                m_sda_oen_i = N'($urandom);
                x_scl_oen   = bit_at(m_scl_oen_i, owner);
                x_sda_oen   = bit_at(m_sda_oen_i, owner);
                x_sda_o     = bit_at(m_sda_o_i, owner);
                step();
                checks++;
                if (gnt_o !== (N'(1) << owner) || scl_padoen_o !== x_scl_oen ||
                    sda_padoen_o !== x_sda_oen || sda_pad_o !== x_sda_o)
                    $display("FAIL rr_hold%0d: gnt=%b scl_oen=%b sda_oen=%b sda_o=%b, expected %b %b %b %b",
                             r, gnt_o, scl_padoen_o, sda_padoen_o, sda_pad_o,
                             N'(1) << owner, x_scl_oen, x_sda_oen, x_sda_o);
                else passed++;
            end
            req_i = ~(N'(1) << owner);
            step();
            checks++;
            if (gnt_o !== '0 || scl_padoen_o !== 1'b1 || sda_padoen_o !== 1'b1)
                $display("FAIL rr_drop%0d: gnt=%b scl_oen=%b sda_oen=%b, expected 000 1 1",
                         r, gnt_o, scl_padoen_o, sda_padoen_o);
            else passed++;
            req_i  = '1;
            waited = 0;
            while (gnt_o === '0 && waited < G + 5) begin
                step();
                waited++;
            end
            nxt = (owner + 1) % N;
            checks++;
            if (gnt_o !== (N'(1) << nxt) || waited != G + 1)
                $display("FAIL rr_order%0d: gnt=%b after %0d cycles, expected %b after %0d",
                         r, gnt_o, waited, N'(1) << nxt, G + 1);
            else passed++;
            owner = nxt;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(11, 0) == 0) req_i[i] = ~req_i[i];
            end
            m_scl_o_i   = N'($urandom);
            m_scl_oen_i = N'($urandom);
            m_sda_o_i   = N'($urandom);
            m_sda_oen_i = N'($urandom);
            step();
            checks++;
            if (gnt_o !== e_gnt || busy_o !== e_busy || scl_pad_o !== e_scl_o || scl_padoen_o !== e_scl_oen ||
                sda_pad_o !== e_sda_o || sda_padoen_o !== e_sda_oen)
                $display("FAIL random_c%0d: gnt=%b busy=%b scl=%b/%b sda=%b/%b, expected %b %b %b/%b %b/%b",
                         c, gnt_o, busy_o, scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o,
                         e_gnt, e_busy, e_scl_o, e_scl_oen, e_sda_o, e_sda_oen);
            else passed++;
        end
    endtask

`ifdef SI5340_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int waited;
        arstn_i = 1'b0;
        model_reset();
        req_i = '0;
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;
        req_i   = 3'b001;
        step();
        repeat (TO - 1) step();
        checks++;
        if (gnt_o !== 3'b001 || timeout_o !== 1'b0)
            $display("FAIL to_hold: gnt=%b to=%b, expected 001 0", gnt_o, timeout_o);
        else passed++;
        req_i = 3'b011;
        step();
        checks++;
        if (gnt_o !== '0 || timeout_o !== 1'b1 || scl_padoen_o !== 1'b1)
            $display("FAIL to_revoke: gnt=%b to=%b scl_oen=%b, expected 000 1 1", gnt_o, timeout_o, scl_padoen_o);
        else passed++;
        repeat (G + 1) step();
        checks++;
        if (gnt_o !== 3'b010)
            $display("FAIL to_next: gnt=%b, expected 010", gnt_o);
        else passed++;
        req_i = 3'b001;
        repeat (G + 4) step();
        checks++;
        if (gnt_o !== '0 || timeout_o !== 1'b1)
            $display("FAIL to_blocked: gnt=%b to=%b, expected 000 1", gnt_o, timeout_o);
        else passed++;
        req_i = '0;
        step();
        req_i  = 3'b001;
        waited = 0;
        while (gnt_o === '0 && waited < 4) begin
            step();
            waited++;
        end
        checks++;
        if (gnt_o !== 3'b001)
            $display("FAIL to_unblock: gnt=%b, expected 001", gnt_o);
        else passed++;
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_request();
        test_guard();
        test_reset_mid_grant();
        test_round_robin();
`ifdef SI5340_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_random();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
